waterfall_ctrl: RTL and testbench

- Controller that sequences the dual-port bram as a circular buffer of spectrum rows for the waterfall display.
- Write side accepts a stream of FFT bin magnitudes with a valid/ready handshake and packs each COLS-bin row into the next BRAM row.
- Read side serves pixel lookups from the display scanner. y=0 is the newest completed row, so the image scrolls.
- Sits between the FFT output stage and the display driver. Owns all BRAM address generation.

---
 rtl/waterfall_pkg.sv | 27 ++
 rtl/waterfall_ctrl_row_map.sv | 18 +
 rtl/waterfall_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_waterfall_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/waterfall_pkg.sv
// Shared definitions for the waterfall display path: geometry defaults used by
// the FFT stage, this controller and the display driver, plus the write FSM
// state encoding. Optional feature macro: WATERFALL_CLEAR_EN (adds the CLEAR
// sweep state).
package waterfall_pkg;

  localparam int COLS   = 32;
  localparam int ROWS   = 16;
  localparam int DATA_W = 8;
  localparam int COL_W  = 5;
  localparam int ROW_W  = 4;
  localparam int ADDR_W = COL_W + ROW_W;

`ifdef WATERFALL_CLEAR_EN
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    COMMIT = 2'd1,
    CLEAR  = 2'd2
  } wf_state_e;
`else
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    COMMIT = 2'd1
  } wf_state_e;
`endif

endpackage

// File: rtl/waterfall_ctrl_row_map.sv
// Maps a pixel row age onto a physical BRAM row of the circular buffer and
// flags ages that have no committed row behind them yet.
module waterfall_ctrl_row_map
  import waterfall_pkg::*;
(
  input  logic [ROW_W-1:0] i_head,
  input  logic [ROW_W-1:0] i_pix_y,
  input  logic [ROW_W-1:0] i_rows_filled,
  output logic [ROW_W-1:0] o_row,
  output logic             o_blank
);

  // head is the row being filled; age 0 is the row just behind it. The
  // subtraction wraps naturally at ROW_W bits because ROWS is a power of two.
  assign o_row   = i_head - ROW_W'(1) - i_pix_y;
  assign o_blank = (i_pix_y >= i_rows_filled);

endmodule

// File: rtl/waterfall_ctrl.sv
// Waterfall controller: packs streamed FFT bins into rows of an external
// dual-port BRAM used as a circular buffer, and serves pixel lookups where
// y=0 is the newest completed row. The BRAM itself sits beside this block.
// Optional feature macro: WATERFALL_CLEAR_EN -- when defined, clear sweeps
// zeros through the whole BRAM; otherwise clear only resets the pointers.
module waterfall_ctrl
  import waterfall_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bin_data,
  input  logic              bin_valid,
  output logic              bin_ready,
  input  logic              freeze,
  input  logic              clear,
  input  logic              pix_req,
  input  logic [COL_W-1:0]  pix_x,
  input  logic [ROW_W-1:0]  pix_y,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [ROW_W-1:0]  rows_filled,
  output logic              row_done,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_d_in,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_d_out
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  wf_state_e           r_state;
  wf_state_e           w_state_nxt;
  logic [ROW_W-1:0]    r_head;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_rows_filled;
  logic                r_pix_valid;
  logic                r_blank;
  logic [ROW_W-1:0]    w_row;
  logic                w_blank;
  logic                w_bin_ready;
  logic                w_handshake;
  logic                w_w_en;
  logic [ADDR_W-1:0]   w_w_addr;
  logic [DATA_W-1:0]   w_d_in;
  logic                w_row_done;

`ifdef WATERFALL_CLEAR_EN
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROWS * COLS - 1);
  logic [ADDR_W-1:0]   r_clr_addr;
`endif

  waterfall_ctrl_row_map u_row_map (
    .i_head        (r_head),
    .i_pix_y       (pix_y),
    .i_rows_filled (r_rows_filled),
    .o_row         (w_row),
    .o_blank       (w_blank)
  );

  // Write FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and combinational write-port drive; clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_ready = 1'b0;
    w_handshake = 1'b0;
    w_w_en      = 1'b0;
    w_w_addr    = {ADDR_W{1'b0}};
    w_d_in      = {DATA_W{1'b0}};
    w_row_done  = 1'b0;
    case (r_state)
      FILL: begin
        w_bin_ready = ~freeze & ~clear;
        w_handshake = bin_valid & w_bin_ready;
        if (w_handshake) begin
          w_w_en   = 1'b1;
          w_w_addr = {r_head, r_col};
          w_d_in   = bin_data;
          if (r_col == COL_LAST) begin
            w_state_nxt = COMMIT;
          end else begin
            w_state_nxt = FILL;
          end
        end else begin
          w_state_nxt = FILL;
        end
      end
      COMMIT: begin
        // A coincident clear throws the row away, so it is not announced.
        w_row_done  = ~clear;
        w_state_nxt = FILL;
      end
`ifdef WATERFALL_CLEAR_EN
      CLEAR: begin
        if (clear) begin
          w_state_nxt = CLEAR;
        end else begin
          w_w_en   = 1'b1;
          w_w_addr = r_clr_addr;
          if (r_clr_addr == ADDR_LAST) begin
            w_state_nxt = FILL;
          end else begin
            w_state_nxt = CLEAR;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = FILL;
      end
    endcase
    if (clear) begin
`ifdef WATERFALL_CLEAR_EN
      w_state_nxt = CLEAR;
`else
      w_state_nxt = FILL;
`endif
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Row/column pointers and visible-row count; clear wipes the partial row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head        <= {ROW_W{1'b0}};
      r_col         <= {COL_W{1'b0}};
      r_rows_filled <= {ROW_W{1'b0}};
    end else if (clear) begin
      r_head        <= {ROW_W{1'b0}};
      r_col         <= {COL_W{1'b0}};
      r_rows_filled <= {ROW_W{1'b0}};
    end else begin
      if (w_handshake) begin
        r_col <= r_col + COL_W'(1);
      end
      if (r_state == COMMIT) begin
        r_head <= r_head + ROW_W'(1);
        // The row at head is never readable, so at most ROWS-1 are visible.
        if (r_rows_filled != ROW_LAST) begin
          r_rows_filled <= r_rows_filled + ROW_W'(1);
        end
      end
    end
  end

`ifdef WATERFALL_CLEAR_EN
  // Sweep address for zeroing the BRAM; a new clear restarts it at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_addr <= {ADDR_W{1'b0}};
    end else if (clear) begin
      r_clr_addr <= {ADDR_W{1'b0}};
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end
`endif

  // Read pipeline: remember request and blank decision for the BRAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_valid <= 1'b0;
      r_blank     <= 1'b0;
    end else begin
      r_pix_valid <= pix_req;
      r_blank     <= w_blank;
    end
  end

  assign bin_ready   = w_bin_ready;
  assign row_done    = w_row_done;
  assign rows_filled = r_rows_filled;
  assign mem_w_en    = w_w_en;
  assign mem_w_addr  = w_w_addr;
  assign mem_d_in    = w_d_in;
  assign mem_r_en    = pix_req;
  assign mem_r_addr  = pix_req ? {w_row, pix_x} : {ADDR_W{1'b0}};
  assign pix_valid   = r_pix_valid;
  assign pix_data    = (r_pix_valid && !r_blank) ? mem_d_out : {DATA_W{1'b0}};

endmodule

// File: tb/tb_waterfall_ctrl.sv
// Directed self-checking bench for waterfall_ctrl with a behavioural BRAM.
module tb_waterfall_ctrl;
  import waterfall_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] bin_data = '0;
  logic              bin_valid = 1'b0;
  logic              bin_ready;
  logic              freeze = 1'b0;
  logic              clear = 1'b0;
  logic              pix_req = 1'b0;
  logic [COL_W-1:0]  pix_x = '0;
  logic [ROW_W-1:0]  pix_y = '0;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic [ROW_W-1:0]  rows_filled;
  logic              row_done;
  logic [ADDR_W-1:0] mem_w_addr;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_d_in;
  logic [ADDR_W-1:0] mem_r_addr;
  logic              mem_r_en;
  logic [DATA_W-1:0] mem_d_out = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  waterfall_ctrl dut (
    .clk(clk), .reset(reset), .bin_data(bin_data), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .freeze(freeze), .clear(clear), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_data(pix_data),
    .rows_filled(rows_filled), .row_done(row_done), .mem_w_addr(mem_w_addr),
    .mem_w_en(mem_w_en), .mem_d_in(mem_d_in), .mem_r_addr(mem_r_addr),
    .mem_r_en(mem_r_en), .mem_d_out(mem_d_out)
  );

  // Behavioural dual-port BRAM with one-cycle registered read.
  logic [DATA_W-1:0] mem [0:ROWS*COLS-1];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_d_in;
    if (mem_r_en) mem_d_out <= mem[mem_r_addr];
  end

  // Log of write addresses and count of row_done pulses.
  logic [ADDR_W-1:0] wlog [0:4095];
  int wcnt = 0;
  int rdcnt = 0;
  always @(posedge clk) begin
    if (mem_w_en) begin
      if (wcnt < 4096) wlog[wcnt] <= mem_w_addr;
      wcnt <= wcnt + 1;
    end
    if (row_done) rdcnt <= rdcnt + 1;
  end

  task automatic send_bins(input int n, input logic [DATA_W-1:0] d0, input bit incr);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 200) begin
      @(negedge clk);
      bin_valid = 1'b1;
      bin_data = incr ? (d0 + 8'(sent)) : d0;
      #1;
      if (bin_ready) sent++;
      guard++;
    end
    @(negedge clk);
    bin_valid = 1'b0;
    checks++;
    if (sent !== n) begin failures++; $display("FAIL send_bins_timeout got=%0d exp=%0d", sent, n); end
  endtask

  task automatic do_read(input logic [COL_W-1:0] x, input logic [ROW_W-1:0] y,
                         output logic [ADDR_W-1:0] ra, output logic v, output logic [DATA_W-1:0] d);
    @(negedge clk);
    pix_req = 1'b1; pix_x = x; pix_y = y;
    #1;
    ra = mem_r_addr;
    @(negedge clk);
    pix_req = 1'b0;
    #1;
    v = pix_valid;
    d = pix_data;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (bin_ready !== 1'b1) begin failures++; $display("FAIL reset_bin_ready got=%0h exp=1", bin_ready); end
    checks++; if (rows_filled !== 4'd0) begin failures++; $display("FAIL reset_rows_filled got=%0h exp=0", rows_filled); end
    checks++; if ({row_done, mem_w_en, mem_r_en, pix_valid} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {row_done, mem_w_en, mem_r_en, pix_valid}); end
    checks++; if ({mem_w_addr, mem_d_in, mem_r_addr, pix_data} !== 34'd0) begin failures++; $display("FAIL reset_buses got=%0h exp=0", {mem_w_addr, mem_d_in, mem_r_addr, pix_data}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_first_row();
    int base = wcnt;
    logic [ADDR_W-1:0] ra; logic v; logic [DATA_W-1:0] d;
    send_bins(32, 8'h00, 1'b1);
    #1;
    checks++; if (row_done !== 1'b1) begin failures++; $display("FAIL row1_row_done got=%0h exp=1", row_done); end
    checks++; if (bin_ready !== 1'b0) begin failures++; $display("FAIL row1_commit_ready got=%0h exp=0", bin_ready); end
    checks++; if (wcnt - base !== 32) begin failures++; $display("FAIL row1_write_count got=%0d exp=32", wcnt - base); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (wlog[base+i] !== ADDR_W'(i) || mem[i] !== DATA_W'(i)) begin
        failures++; $display("FAIL row1_write_%0d got=%0h/%0h exp=%0h", i, wlog[base+i], mem[i], i);
      end
    end
    @(negedge clk); #1;
    checks++; if (rows_filled !== 4'd1) begin failures++; $display("FAIL row1_rows_filled got=%0d exp=1", rows_filled); end
    checks++; if (bin_ready !== 1'b1) begin failures++; $display("FAIL row1_ready_after got=%0h exp=1", bin_ready); end
    do_read(5'd5, 4'd0, ra, v, d);
    checks++; if (ra !== 9'd5) begin failures++; $display("FAIL read_y0_addr got=%0h exp=5", ra); end
    checks++; if (v !== 1'b1 || d !== 8'h05) begin failures++; $display("FAIL read_y0_data got=%0h/%0h exp=1/05", v, d); end
    do_read(5'd5, 4'd1, ra, v, d);
    checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL read_y1_blank got=%0h/%0h exp=1/00", v, d); end
  endtask

  task automatic test_fill_20();
    logic [ADDR_W-1:0] ra; logic v; logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_b2b [0:2];
    exp_b2b[0] = 8'd19; exp_b2b[1] = 8'd18; exp_b2b[2] = 8'd17;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 20; k++) send_bins(32, DATA_W'(k), 1'b0);
    @(negedge clk); #1;
    checks++; if (rows_filled !== 4'd15) begin failures++; $display("FAIL fill20_rows_filled got=%0d exp=15", rows_filled); end
    do_read(5'd7, 4'd0, ra, v, d);
    checks++; if (ra !== 9'd103) begin failures++; $display("FAIL fill20_y0_addr got=%0d exp=103", ra); end
    checks++; if (v !== 1'b1 || d !== 8'd19) begin failures++; $display("FAIL fill20_y0 got=%0h/%0d exp=1/19", v, d); end
    do_read(5'd0, 4'd14, ra, v, d);
    checks++; if (d !== 8'd5) begin failures++; $display("FAIL fill20_y14 got=%0d exp=5", d); end
    do_read(5'd0, 4'd15, ra, v, d);
    checks++; if (v !== 1'b1 || d !== 8'd0) begin failures++; $display("FAIL fill20_y15_blank got=%0h/%0d exp=1/0", v, d); end
    // back-to-back reads, one per cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== exp_b2b[i-1]) begin
          failures++; $display("FAIL b2b_read_%0d got=%0h/%0d exp=1/%0d", i-1, pix_valid, pix_data, exp_b2b[i-1]);
        end
      end
      pix_req = (i < 3); pix_x = 5'd2; pix_y = ROW_W'(i);
    end
  endtask

  task automatic test_freeze();
    int base; int rd0;
    logic [ADDR_W-1:0] ra; logic v; logic [DATA_W-1:0] d;
    send_bins(11, 8'h40, 1'b1);
    base = wcnt; rd0 = rdcnt;
    freeze = 1'b1; bin_valid = 1'b1; bin_data = 8'h4B;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (bin_ready !== 1'b0 || mem_w_en !== 1'b0) begin failures++; $display("FAIL freeze_cycle_%0d got=%b exp=00", i, {bin_ready, mem_w_en}); end
      @(negedge clk);
    end
    freeze = 1'b0; bin_valid = 1'b0;
    checks++; if (wcnt !== base) begin failures++; $display("FAIL freeze_no_write got=%0d exp=%0d", wcnt, base); end
    send_bins(20, 8'h4B, 1'b1);
    checks++; if (rdcnt !== rd0) begin failures++; $display("FAIL freeze_early_row_done got=%0d exp=%0d", rdcnt, rd0); end
    send_bins(1, 8'h5F, 1'b1);
    #1;
    checks++; if (row_done !== 1'b1) begin failures++; $display("FAIL freeze_row_done got=%0h exp=1", row_done); end
    checks++; if (wcnt - base !== 21) begin failures++; $display("FAIL freeze_write_count got=%0d exp=21", wcnt - base); end
    do_read(5'd10, 4'd0, ra, v, d);
    checks++; if (d !== 8'h4A) begin failures++; $display("FAIL freeze_x10 got=%0h exp=4a", d); end
    do_read(5'd31, 4'd0, ra, v, d);
    checks++; if (d !== 8'h5F) begin failures++; $display("FAIL freeze_x31 got=%0h exp=5f", d); end
    do_read(5'd0, 4'd1, ra, v, d);
    checks++; if (d !== 8'h13) begin failures++; $display("FAIL freeze_y1 got=%0h exp=13", d); end
    do_read(5'd0, 4'd14, ra, v, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL freeze_y14 got=%0h exp=06", d); end
  endtask

  task automatic test_clear();
    int base;
    logic [ADDR_W-1:0] ra; logic v; logic [DATA_W-1:0] d;
`ifdef WATERFALL_CLEAR_EN
    int bad = 0;
`endif
    send_bins(20, 8'h60, 1'b1);
    base = wcnt;
    bin_valid = 1'b1; bin_data = 8'h74; clear = 1'b1;
    #1;
    checks++; if (bin_ready !== 1'b0 || mem_w_en !== 1'b0) begin failures++; $display("FAIL clear_hs_blocked got=%b exp=00", {bin_ready, mem_w_en}); end
    @(negedge clk);
    clear = 1'b0; bin_valid = 1'b0;
    #1;
    checks++; if (rows_filled !== 4'd0) begin failures++; $display("FAIL clear_rows_filled got=%0d exp=0", rows_filled); end
    checks++; if (wcnt !== base) begin failures++; $display("FAIL clear_no_write got=%0d exp=%0d", wcnt, base); end
`ifdef WATERFALL_CLEAR_EN
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (!(mem_w_en === 1'b1 && mem_w_addr === ADDR_W'(i) && mem_d_in === 8'd0 && bin_ready === 1'b0)) bad++;
      @(negedge clk); #1;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL clear_sweep bad_cycles=%0d exp=0", bad); end
    checks++; if (wcnt - base !== 512) begin failures++; $display("FAIL clear_sweep_count got=%0d exp=512", wcnt - base); end
`endif
    checks++; if (bin_ready !== 1'b1) begin failures++; $display("FAIL clear_ready_after got=%0h exp=1", bin_ready); end
    do_read(5'd0, 4'd0, ra, v, d);
    checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL clear_read_blank got=%0h/%0h exp=1/00", v, d); end
    base = wcnt;
    send_bins(32, 8'h70, 1'b1);
    #1;
    checks++; if (row_done !== 1'b1) begin failures++; $display("FAIL clear_row_done got=%0h exp=1", row_done); end
    checks++; if (wlog[base] !== 9'd0 || wlog[base+31] !== 9'd31) begin failures++; $display("FAIL clear_row_addr got=%0d..%0d exp=0..31", wlog[base], wlog[base+31]); end
    @(negedge clk); #1;
    checks++; if (rows_filled !== 4'd1) begin failures++; $display("FAIL clear_row_filled got=%0d exp=1", rows_filled); end
    do_read(5'd3, 4'd0, ra, v, d);
    checks++; if (ra !== 9'd3 || d !== 8'h73) begin failures++; $display("FAIL clear_row_read got=%0h/%0h exp=3/73", ra, d); end
  endtask

  task automatic test_async_reset();
    int base;
    logic [ADDR_W-1:0] ra; logic v; logic [DATA_W-1:0] d;
    send_bins(10, 8'h90, 1'b1);
    #3; reset = 1'b1;
    #1;
    checks++; if (rows_filled !== 4'd0) begin failures++; $display("FAIL areset_rows_filled got=%0d exp=0", rows_filled); end
    checks++; if ({bin_ready, row_done, mem_w_en, pix_valid} !== 4'b1000) begin failures++; $display("FAIL areset_flags got=%b exp=1000", {bin_ready, row_done, mem_w_en, pix_valid}); end
    @(negedge clk); reset = 1'b0;
    base = wcnt;
    send_bins(32, 8'hA0, 1'b1);
    #1;
    checks++; if (wcnt - base !== 32) begin failures++; $display("FAIL areset_write_count got=%0d exp=32", wcnt - base); end
    checks++; if (wlog[base] !== 9'd0 || wlog[base+31] !== 9'd31) begin failures++; $display("FAIL areset_row_addr got=%0d..%0d exp=0..31", wlog[base], wlog[base+31]); end
    @(negedge clk); #1;
    checks++; if (rows_filled !== 4'd1) begin failures++; $display("FAIL areset_rows_after got=%0d exp=1", rows_filled); end
    do_read(5'd0, 4'd0, ra, v, d);
    checks++; if (d !== 8'hA0) begin failures++; $display("FAIL areset_read got=%0h exp=a0", d); end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_fill_20();
    test_freeze();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
